// File: rtl/mkio_pkg.sv
// Shared MKIO definitions for the remote-terminal transmit path.
// The sequencer state encodings live here so that other blocks and
// the bench can decode them consistently.
package mkio_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_RD   = 3'd1;
  localparam logic [ST_W-1:0] ST_LAT  = 3'd2;
  localparam logic [ST_W-1:0] ST_PRES = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

  // A word count field of 0 on the MKIO bus means this many words.
  localparam int MKIO_MAX_WORDS = 32;

endpackage

// File: rtl/dev3_rd_ctrl_if.sv
// Word handshake between the device-3 read sequencer and the MKIO word
// transmitter.
//   tx_data  : word presented to the transmitter
//   tx_valid : tx_data is valid
//   tx_ready : transmitter accepts tx_data at the next clock edge
// master = sequencer side, slave = transmitter side.
interface dev3_rd_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dev3_rd_ctrl.sv
// Read-side sequencer for the device-3 subaddress buffer RAM.
// On start, fetches word_cnt words from consecutive RAM addresses
// (modulo buffer depth) and presents each to the transmitter over a
// valid/ready handshake. RAM read latency is one cycle.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : command pulse, honoured in IDLE only
//   base_addr          : first RAM address (sampled with start)
//   word_cnt           : word count, 0 = full buffer (sampled with start)
//   abort              : drop the transfer, return to IDLE, no done
//   rdaddress / q      : RAM read port
//   tx (master)        : tx_data / tx_valid / tx_ready handshake
//   busy               : not IDLE
//   done               : one-cycle pulse after the last accepted word
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | waiting for start
// RD      | rdaddress stable, RAM samples it
// LAT     | q valid, captured into tx_data
// PRES    | tx_valid high until handshake
// DONE    | done pulse, then IDLE
module dev3_rd_ctrl
  import mkio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_cnt,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] q,
  dev3_rd_ctrl_if.master        tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  // A zero count field means the whole buffer, hence the extra bit.
  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rdaddress   <= '0;
      remaining   <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // abort wins over a coincident start
          if (start && !abort) begin
            rdaddress <= base_addr;
            remaining <= (word_cnt == '0) ? FULL_CNT : {1'b0, word_cnt};
            state     <= ST_RD;
          end
        end
        ST_RD: begin
          state <= abort ? ST_IDLE : ST_LAT;
        end
        ST_LAT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            tx.tx_data  <= q;
            tx.tx_valid <= 1'b1;
            state       <= ST_PRES;
          end
        end
        ST_PRES: begin
          // abort beats a same-cycle handshake; that word is not sent
          if (abort) begin
            tx.tx_valid <= 1'b0;
            state       <= ST_IDLE;
          end else if (tx.tx_ready) begin
            tx.tx_valid <= 1'b0;
            remaining   <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
            end else begin
              rdaddress <= rdaddress + 1'b1;
              state     <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          tx.tx_valid <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_dev3_rd_ctrl.sv
module tb_dev3_rd_ctrl;
  import mkio_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_cnt;
  logic          abort;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;
  logic          busy;
  logic          done;

  dev3_rd_ctrl_if #(.DATA_WIDTH(DW)) tx ();

  dev3_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .abort     (abort),
    .rdaddress (rdaddress),
    .q         (q),
    .tx        (tx.master),
    .busy      (busy),
    .done      (done)
  );

  // Buffer RAM read port: registered read, one-cycle latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) q <= mem[rdaddress];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;
  int cyc = 0;

  // Transaction-level reference: a transfer is a list of words, each
  // appearing two edges after the previous handshake (or the start)
  // and held until accepted.
  bit m_active, m_valid, m_done;
  int m_wait, m_addr, m_data, m_left;

  initial begin
    m_active = 0; m_valid = 0; m_done = 0;
    m_wait = 0; m_addr = 0; m_data = 0; m_left = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 0; m_valid = 0; m_done = 0;
      m_addr = 0; m_data = 0; m_left = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1;
        m_addr   = int'(base_addr);
        m_left   = (word_cnt == 0) ? MKIO_MAX_WORDS : int'(word_cnt);
        m_wait   = 2;
      end
    end else if (abort) begin
      m_active = 0;
      m_valid  = 0;
    end else if (m_valid) begin
      if (tx.tx_ready) begin
        m_valid = 0;
        m_left--;
        if (m_left == 0) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_addr = (m_addr + 1) % DEPTH;
          m_wait = 2;
        end
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1;
        m_data  = int'(mem[m_addr]);
      end
    end
  end

  // Accepted-word log used by the literal checks.
  int acc[$];
  int acc_cyc[$];
  int done_count = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (int'(rdaddress) != m_addr || int'(tx.tx_data) != m_data ||
          tx.tx_valid != m_valid || busy != (m_active || m_done) ||
          done != m_done) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got addr=%0d data=%h valid=%0b busy=%0b done=%0b, want addr=%0d data=%h valid=%0b busy=%0b done=%0b",
                 cyc, rdaddress, tx.tx_data, tx.tx_valid, busy, done,
                 m_addr, m_data[15:0], m_valid, m_active || m_done, m_done);
      end
      if (!reset && !abort && tx.tx_valid && tx.tx_ready) begin
        acc.push_back(int'(tx.tx_data));
        acc_cyc.push_back(cyc);
      end
      if (done) done_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int acc_at(input int i);
    return (i < acc.size()) ? acc[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1000;
  endfunction

  task automatic clear_log();
    acc.delete();
    acc_cyc.delete();
    done_count = 0;
  endtask

  int start_cyc;

  task automatic start_xfer(input int b, input int c);
    base_addr = AW'(b);
    word_cnt  = AW'(c);
    start     = 1'b1;
    tick();
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    if (busy) begin
      miscompares++;
      $display("FAIL %s: timeout waiting for idle after %0d cycles", name, max);
    end
  endtask

  task automatic wait_acc(input string name, input int cnt, input int max);
    int n = 0;
    while (acc.size() < cnt && n < max) begin
      tick();
      n++;
    end
    if (acc.size() < cnt) begin
      miscompares++;
      $display("FAIL %s: timeout, got %0d words want %0d", name, acc.size(), cnt);
    end
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!tx.tx_valid && n < max) begin
      tick();
      n++;
    end
    if (!tx.tx_valid) begin
      miscompares++;
      $display("FAIL %s: timeout waiting for tx_valid", name);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA000 + 16'(i);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; word_cnt = '0; tx.tx_ready = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("reset rdaddress", int'(rdaddress), 0);
    chk("reset busy", int'(busy), 0);
    reset = 1'b0;
    tick();

    // Basic 3-word transfer with ready held high.
    clear_log();
    tx.tx_ready = 1'b1;
    start_xfer(4, 3);
    chk("start rdaddress", int'(rdaddress), 4);
    chk("start busy", int'(busy), 1);
    wait_idle("basic", 100);
    chk("basic count", acc.size(), 3);
    chk("basic w0", acc_at(0), 16'hA004);
    chk("basic w1", acc_at(1), 16'hA005);
    chk("basic w2", acc_at(2), 16'hA006);
    chk("basic first valid latency", cyc_at(0) - start_cyc, 2);
    chk("basic cadence", cyc_at(1) - cyc_at(0), 3);
    chk("basic done pulses", done_count, 1);

    // Full buffer: count field 0.
    clear_log();
    start_xfer(0, 0);
    wait_idle("full", 400);
    chk("full count", acc.size(), MKIO_MAX_WORDS);
    chk("full first", acc_at(0), 16'hA000);
    chk("full last", acc_at(31), 16'hA01F);
    chk("full final rdaddress", int'(rdaddress), 31);
    chk("full done pulses", done_count, 1);

    // Address wrap.
    clear_log();
    start_xfer(30, 4);
    wait_idle("wrap", 100);
    chk("wrap w0", acc_at(0), 16'hA01E);
    chk("wrap w1", acc_at(1), 16'hA01F);
    chk("wrap w2", acc_at(2), 16'hA000);
    chk("wrap w3", acc_at(3), 16'hA001);

    // Backpressure on word 2.
    clear_log();
    start_xfer(8, 3);
    wait_acc("bp w0", 1, 50);
    tx.tx_ready = 1'b0;
    repeat (10) tick();
    chk("bp held valid", int'(tx.tx_valid), 1);
    chk("bp held data", int'(tx.tx_data), 16'hA009);
    chk("bp held addr", int'(rdaddress), 9);
    tx.tx_ready = 1'b1;
    wait_idle("bp", 100);
    chk("bp w1", acc_at(1), 16'hA009);
    chk("bp resume cadence", cyc_at(2) - cyc_at(1), 3);
    chk("bp stall length", int'(cyc_at(1) - cyc_at(0) >= 10), 1);

    // Abort on the second handshake of a 5-word transfer.
    clear_log();
    start_xfer(0, 5);
    wait_acc("abort w0", 1, 50);
    tick();
    wait_valid("abort w1", 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort valid", int'(tx.tx_valid), 0);
    chk("abort busy", int'(busy), 0);
    repeat (3) tick();
    chk("abort words", acc.size(), 1);
    chk("abort done", done_count, 0);
    clear_log();
    start_xfer(10, 2);
    wait_idle("after abort", 50);
    chk("after abort w0", acc_at(0), 16'hA00A);
    chk("after abort w1", acc_at(1), 16'hA00B);
    chk("after abort done", done_count, 1);

    // Reset during PRES.
    clear_log();
    tx.tx_ready = 1'b0;
    start_xfer(3, 5);
    wait_valid("reset pres", 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst data", int'(tx.tx_data), 0);
    chk("rst valid", int'(tx.tx_valid), 0);
    chk("rst addr", int'(rdaddress), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    tick();
    chk("rst no done", done_count, 0);

    // start while busy is ignored.
    clear_log();
    tx.tx_ready = 1'b1;
    start_xfer(20, 3);
    tick();
    start_xfer(0, 7);
    wait_idle("start busy", 100);
    chk("start busy count", acc.size(), 3);
    chk("start busy w0", acc_at(0), 16'hA014);
    chk("start busy w2", acc_at(2), 16'hA016);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    repeat (3000) begin
      tx.tx_ready = ($urandom_range(3) != 0);
      start       = ($urandom_range(7) == 0);
      base_addr   = AW'($urandom);
      word_cnt    = ($urandom_range(19) == 0) ? '0 : AW'($urandom_range(6));
      abort       = ($urandom_range(49) == 0);
      reset       = ($urandom_range(299) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0; tx.tx_ready = 1'b1;
    wait_idle("random drain", 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
